// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// PC-source and write-back-source selects, and the one-hot instruction class.
// Pure declarations; no logic or state.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    localparam logic [6:0] OP_ALU_REG = 7'b0110011;
    localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OP_FENCE   = 7'b0001111;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JALR   = 2'b10;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_IMM  = 2'b11;

    // One bit per instruction class; at most one bit set for a legal opcode.
    typedef struct packed {
        logic alu_reg;
        logic alu_imm;
        logic load;
        logic store;
        logic branch;
        logic jal;
        logic jalr;
        logic lui;
        logic auipc;
        logic system;
        logic fence;
    } op_class_t;

    // Register-file write-back source for a class reaching WRITEBACK.
    function automatic logic [1:0] wb_sel_of(input op_class_t c);
        if (c.load)                 return WB_SEL_LOAD;
        else if (c.jal || c.jalr)   return WB_SEL_PC4;
        else if (c.lui || c.auipc)  return WB_SEL_IMM;
        else                        return WB_SEL_ALU;
    endfunction

    // Next-PC source for a class reaching WRITEBACK.
    function automatic logic [1:0] pc_src_of(input op_class_t c);
        if (c.jal)       return PC_SRC_BRANCH;
        else if (c.jalr) return PC_SRC_JALR;
        else             return PC_SRC_PLUS4;
    endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Opcode to one-hot instruction class plus an illegal flag for unknown opcodes.
// Purely combinational, zero latency.
// No handshake; the caller decides when the class is meaningful.
module opcode_classifier
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output op_class_t  class_o,
    output logic       illegal_o
);

    // Decode the 7-bit major opcode; anything unlisted is illegal.
    always_comb begin
        class_o   = '0;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_ALU_REG: class_o.alu_reg = 1'b1;
            OP_ALU_IMM: class_o.alu_imm = 1'b1;
            OP_LOAD:    class_o.load    = 1'b1;
            OP_STORE:   class_o.store   = 1'b1;
            OP_BRANCH:  class_o.branch  = 1'b1;
            OP_JAL:     class_o.jal     = 1'b1;
            OP_JALR:    class_o.jalr    = 1'b1;
            OP_LUI:     class_o.lui     = 1'b1;
            OP_AUIPC:   class_o.auipc   = 1'b1;
            OP_SYSTEM:  class_o.system  = 1'b1;
            OP_FENCE:   class_o.fence   = 1'b1;
            default:    illegal_o       = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM sharing one memory port between fetch and load/store.
// Zero-wait latency: branch 3, ALU/jump/lui/auipc/store 4, load 5 cycles.
// Stalls in FETCH/MEMORY until mem_ready; a request unanswered for MEM_WAIT_MAX cycles traps and halts.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int RETIRE_WIDTH = 32,
    parameter int MEM_WAIT_MAX = 15
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              opcode,
    input  logic                    inst_valid,
    input  logic                    mem_ready,
    input  logic                    branch_taken,
    output logic                    mem_req,
    output logic                    mem_sel,
    output logic                    mem_we,
    output logic                    ir_we,
    output logic                    alu_execute,
    output logic                    rf_we,
    output logic                    pc_we,
    output logic [1:0]              pc_src,
    output logic [1:0]              wb_sel,
    output logic                    halted,
    output logic                    trap,
    output logic [2:0]              state,
    output logic [RETIRE_WIDTH-1:0] retired
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    state_e                  state_q;
    op_class_t               class_q;
    logic [WAIT_W-1:0]       wait_q;
    logic [WAIT_W-1:0]       wait_d;
    logic [RETIRE_WIDTH-1:0] retired_q;
    logic [RETIRE_WIDTH-1:0] retired_d;
    logic                    halted_q;
    logic                    trap_q;

    op_class_t dec_class;
    logic      dec_illegal;
    logic      wait_expired;

    opcode_classifier u_classifier (
        .opcode_i  (opcode),
        .class_o   (dec_class),
        .illegal_o (dec_illegal)
    );

    // The cycle that would be the MEM_WAIT_MAX-th without mem_ready ends the request.
    assign wait_expired = (wait_q == WAIT_W'(MEM_WAIT_MAX - 1));
    assign wait_d       = wait_q + WAIT_W'(1);
    assign retired_d    = retired_q + RETIRE_WIDTH'(1);

    // Instruction sequencing, memory wait timer, retire counter and sticky halt/trap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            class_q   <= '0;
            wait_q    <= '0;
            retired_q <= '0;
            halted_q  <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_ready) begin
                        wait_q <= '0;
                        if (inst_valid) begin
                            state_q <= ST_DECODE;
                        end else begin
                            trap_q   <= 1'b1;
                            halted_q <= 1'b1;
                            state_q  <= ST_HALT;
                        end
                    end else if (wait_expired) begin
                        wait_q   <= '0;
                        trap_q   <= 1'b1;
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                ST_DECODE: begin
                    class_q <= dec_class;
                    if (dec_illegal || dec_class.fence) begin
                        trap_q   <= 1'b1;
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else if (dec_class.system) begin
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else begin
                        state_q <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (class_q.system || class_q.fence) begin
                        // Never reached from DECODE; keeps a stray class from reaching write-back.
                        trap_q   <= 1'b1;
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else if (class_q.load || class_q.store) begin
                        state_q <= ST_MEMORY;
                    end else if (class_q.branch) begin
                        retired_q <= retired_d;
                        state_q   <= ST_FETCH;
                    end else begin
                        state_q <= ST_WRITEBACK;
                    end
                end
                ST_MEMORY: begin
                    if (mem_ready) begin
                        wait_q <= '0;
                        if (class_q.store) begin
                            retired_q <= retired_d;
                            state_q   <= ST_FETCH;
                        end else begin
                            state_q <= ST_WRITEBACK;
                        end
                    end else if (wait_expired) begin
                        wait_q   <= '0;
                        trap_q   <= 1'b1;
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                ST_WRITEBACK: begin
                    retired_q <= retired_d;
                    state_q   <= ST_FETCH;
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    trap_q   <= 1'b1;
                    halted_q <= 1'b1;
                    state_q  <= ST_HALT;
                end
            endcase
        end
    end

    // Strobes decoded from state and registered class; completion strobes also look at mem_ready/branch_taken.
    always_comb begin
        mem_req     = 1'b0;
        mem_sel     = 1'b0;
        mem_we      = 1'b0;
        ir_we       = 1'b0;
        alu_execute = 1'b0;
        rf_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = PC_SRC_PLUS4;
        wb_sel      = WB_SEL_ALU;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready & inst_valid;
                end
                ST_EXECUTE: begin
                    alu_execute = class_q.alu_reg | class_q.alu_imm | class_q.load |
                                  class_q.store   | class_q.jalr    | class_q.auipc;
                    if (class_q.branch) begin
                        pc_we  = 1'b1;
                        pc_src = branch_taken ? PC_SRC_BRANCH : PC_SRC_PLUS4;
                    end
                end
                ST_MEMORY: begin
                    mem_req = 1'b1;
                    mem_sel = 1'b1;
                    mem_we  = class_q.store;
                    pc_we   = class_q.store & mem_ready;
                end
                ST_WRITEBACK: begin
                    rf_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_src = pc_src_of(class_q);
                    wb_sel = wb_sel_of(class_q);
                end
                default: begin
                end
            endcase
        end
    end

    assign state   = state_q;
    assign retired = retired_q;
    assign halted  = halted_q;
    assign trap    = trap_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle strobe/state vectors vs hand-computed rows.
module tb_multicycle_controller;

    localparam logic [2:0] F = 3'd0;
    localparam logic [2:0] D = 3'd1;
    localparam logic [2:0] E = 3'd2;
    localparam logic [2:0] M = 3'd3;
    localparam logic [2:0] W = 3'd4;
    localparam logic [2:0] H = 3'd5;

    localparam logic [6:0] OPC_ADDI  = 7'h13;  // 0x00500093
    localparam logic [6:0] OPC_ALUR  = 7'h33;
    localparam logic [6:0] OPC_LW    = 7'h03;
    localparam logic [6:0] OPC_SW    = 7'h23;
    localparam logic [6:0] OPC_BEQ   = 7'h63;
    localparam logic [6:0] OPC_JAL   = 7'h6F;
    localparam logic [6:0] OPC_JALR  = 7'h67;
    localparam logic [6:0] OPC_LUI   = 7'h37;
    localparam logic [6:0] OPC_AUIPC = 7'h17;
    localparam logic [6:0] OPC_ECALL = 7'h73;  // 0x00000073
    localparam logic [6:0] OPC_FENCE = 7'h0F;  // 0x0000000F

    typedef struct packed {
        logic [2:0] st;
        logic       req, sel, we, ir, alu, rf, pc;
        logic [1:0] src, wb;
        logic       h, t;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = 7'h00;
    logic        inst_valid = 1'b0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_req, mem_sel, mem_we, ir_we, alu_execute, rf_we, pc_we;
    logic [1:0]  pc_src, wb_sel;
    logic        halted, trap;
    logic [2:0]  state;
    logic [31:0] retired;

    int checks = 0;
    int failures = 0;

    obs_t obs;

    multicycle_controller dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .inst_valid   (inst_valid),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_sel      (mem_sel),
        .mem_we       (mem_we),
        .ir_we        (ir_we),
        .alu_execute  (alu_execute),
        .rf_we        (rf_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .wb_sel       (wb_sel),
        .halted       (halted),
        .trap         (trap),
        .state        (state),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    always_comb obs = {state, mem_req, mem_sel, mem_we, ir_we, alu_execute, rf_we, pc_we,
                       pc_src, wb_sel, halted, trap};

    function automatic obs_t pk(input logic [2:0] st, input logic req, sel, we, ir, alu, rf, pc,
                                input logic [1:0] src, wb, input logic h, t);
        pk = {st, req, sel, we, ir, alu, rf, pc, src, wb, h, t};
    endfunction

    // Entered at a falling edge; leaves at a falling edge with rst low, FSM in its first FETCH cycle.
    task automatic do_reset();
        rst = 1'b1;
        {inst_valid, mem_ready, branch_taken} = 3'b000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e;
        rst = 1'b1;
        opcode = OPC_SW;
        {inst_valid, mem_ready, branch_taken} = 3'b111;
        @(negedge clk);
        #1;
        e = pk(F, 0,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
        checks++;
        if (obs !== e || retired !== 32'd0) begin
            failures++;
            $display("FAIL reset_hold obs=%h retired=%0d expected obs=%h retired=0", obs, retired, e);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        e = pk(F, 1,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL reset_first_fetch obs=%h expected=%h", obs, e);
        end
        @(negedge clk);
    endtask

    task automatic test_addi();
        obs_t e[4];
        logic [2:0] s[4];
        do_reset();
        opcode = OPC_ADDI;
        s = '{3'b110, 3'b000, 3'b000, 3'b000};
        e[0] = pk(F, 1,0,0,1,0,0,0, 2'b00, 2'b00, 0, 0);
        e[1] = pk(D, 0,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
        e[2] = pk(E, 0,0,0,0,1,0,0, 2'b00, 2'b00, 0, 0);
        e[3] = pk(W, 0,0,0,0,0,1,1, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 4; i++) begin
            {inst_valid, mem_ready, branch_taken} = s[i];
            #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL addi cyc%0d obs=%h expected=%h", i, obs, e[i]);
            end
            @(negedge clk);
        end
        {inst_valid, mem_ready, branch_taken} = 3'b000;
        #1;
        checks++;
        if (retired !== 32'd1 || state !== F) begin
            failures++;
            $display("FAIL addi_retire retired=%0d state=%0d expected 1/0", retired, state);
        end
        @(negedge clk);
    endtask

    task automatic test_load_wait();
        obs_t e[8];
        logic [2:0] s[8];
        do_reset();
        opcode = OPC_LW;
        s = '{3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000};
        e[0] = pk(F, 1,0,0,1,0,0,0, 2'b00, 2'b00, 0, 0);
        e[1] = pk(D, 0,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
        e[2] = pk(E, 0,0,0,0,1,0,0, 2'b00, 2'b00, 0, 0);
        for (int i = 3; i < 7; i++) e[i] = pk(M, 1,1,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
        e[7] = pk(W, 0,0,0,0,0,1,1, 2'b00, 2'b01, 0, 0);
        for (int i = 0; i < 8; i++) begin
            {inst_valid, mem_ready, branch_taken} = s[i];
            #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL load_wait cyc%0d obs=%h expected=%h", i, obs, e[i]);
            end
            @(negedge clk);
        end
        {inst_valid, mem_ready, branch_taken} = 3'b000;
        #1;
        checks++;
        if (retired !== 32'd1 || state !== F) begin
            failures++;
            $display("FAIL load_retire retired=%0d state=%0d expected 1/0", retired, state);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back_branch();
        obs_t e[6];
        logic [2:0] s[6];
        do_reset();
        opcode = OPC_BEQ;
        s = '{3'b110, 3'b000, 3'b001, 3'b110, 3'b000, 3'b000};
        e[0] = pk(F, 1,0,0,1,0,0,0, 2'b00, 2'b00, 0, 0);
        e[1] = pk(D, 0,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
        e[2] = pk(E, 0,0,0,0,0,0,1, 2'b01, 2'b00, 0, 0);
        e[3] = pk(F, 1,0,0,1,0,0,0, 2'b00, 2'b00, 0, 0);
        e[4] = pk(D, 0,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
        e[5] = pk(E, 0,0,0,0,0,0,1, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 6; i++) begin
            {inst_valid, mem_ready, branch_taken} = s[i];
            #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL branch cyc%0d obs=%h expected=%h", i, obs, e[i]);
            end
            @(negedge clk);
        end
        {inst_valid, mem_ready, branch_taken} = 3'b000;
        #1;
        checks++;
        if (retired !== 32'd2 || state !== F) begin
            failures++;
            $display("FAIL branch_retire retired=%0d state=%0d expected 2/0", retired, state);
        end
        @(negedge clk);
    endtask

    task automatic test_writeback_sel();
        logic [6:0] op[5];
        logic       ealu[5];
        logic [1:0] wb[5];
        logic [1:0] src[5];
        obs_t       e;
        op   = '{OPC_ALUR, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
        ealu = '{1'b1,     1'b0,    1'b1,     1'b0,    1'b1};
        wb   = '{2'b00,    2'b10,   2'b10,    2'b11,   2'b11};
        src  = '{2'b00,    2'b01,   2'b10,    2'b00,   2'b00};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            opcode = op[k];
            for (int j = 0; j < 4; j++) begin
                {inst_valid, mem_ready, branch_taken} = (j == 0) ? 3'b110 : 3'b000;
                case (j)
                    0:       e = pk(F, 1,0,0,1,0,0,0, 2'b00, 2'b00, 0, 0);
                    1:       e = pk(D, 0,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
                    2:       e = pk(E, 0,0,0,0,ealu[k],0,0, 2'b00, 2'b00, 0, 0);
                    default: e = pk(W, 0,0,0,0,0,1,1, src[k], wb[k], 0, 0);
                endcase
                #1;
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL wb_sel op=%h cyc%0d obs=%h expected=%h", op[k], j, obs, e);
                end
                @(negedge clk);
            end
        end
        {inst_valid, mem_ready, branch_taken} = 3'b000;
        #1;
        checks++;
        if (retired !== 32'd5) begin
            failures++;
            $display("FAIL wb_retire retired=%0d expected=5", retired);
        end
        @(negedge clk);
    endtask

    task automatic test_halt_fence_ecall();
        obs_t e;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            opcode = (k == 0) ? OPC_FENCE : OPC_ECALL;
            for (int i = 0; i < 22; i++) begin
                if (i == 0) {inst_valid, mem_ready, branch_taken} = 3'b110;
                else        {inst_valid, mem_ready, branch_taken} = 3'($urandom_range(7, 0));
                if (i == 0)      e = pk(F, 1,0,0,1,0,0,0, 2'b00, 2'b00, 0, 0);
                else if (i == 1) e = pk(D, 0,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
                else             e = pk(H, 0,0,0,0,0,0,0, 2'b00, 2'b00, 1, (k == 0));
                #1;
                checks++;
                if (obs !== e) begin
                    failures++;
                    $display("FAIL halt_%s cyc%0d obs=%h expected=%h", (k == 0) ? "fence" : "ecall", i, obs, e);
                end
                @(negedge clk);
            end
            checks++;
            if (retired !== 32'd0) begin
                failures++;
                $display("FAIL halt_retire retired=%0d expected=0", retired);
            end
        end
    endtask

    task automatic test_illegal();
        obs_t e;
        // Fetch reported invalid by instruction memory.
        do_reset();
        opcode = OPC_ADDI;
        for (int i = 0; i < 2; i++) begin
            {inst_valid, mem_ready, branch_taken} = (i == 0) ? 3'b010 : 3'b000;
            e = (i == 0) ? pk(F, 1,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0)
                         : pk(H, 0,0,0,0,0,0,0, 2'b00, 2'b00, 1, 1);
            #1;
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL invalid_fetch cyc%0d obs=%h expected=%h", i, obs, e);
            end
            @(negedge clk);
        end
        // Unknown opcode.
        do_reset();
        opcode = 7'h00;
        for (int i = 0; i < 3; i++) begin
            {inst_valid, mem_ready, branch_taken} = (i == 0) ? 3'b110 : 3'b000;
            if (i == 0)      e = pk(F, 1,0,0,1,0,0,0, 2'b00, 2'b00, 0, 0);
            else if (i == 1) e = pk(D, 0,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
            else             e = pk(H, 0,0,0,0,0,0,0, 2'b00, 2'b00, 1, 1);
            #1;
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL unknown_op cyc%0d obs=%h expected=%h", i, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mem_timeout();
        obs_t e;
        do_reset();
        opcode = OPC_ADDI;
        for (int i = 0; i < 16; i++) begin
            {inst_valid, mem_ready, branch_taken} = 3'b100;
            e = (i < 15) ? pk(F, 1,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0)
                         : pk(H, 0,0,0,0,0,0,0, 2'b00, 2'b00, 1, 1);
            #1;
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL fetch_timeout cyc%0d obs=%h expected=%h", i, obs, e);
            end
            @(negedge clk);
        end
    endtask

    // 14 idle cycles is one short of the limit, in FETCH and again in MEMORY.
    task automatic test_wait_boundary();
        obs_t e;
        logic [2:0] s;
        do_reset();
        opcode = OPC_LW;
        for (int i = 0; i < 33; i++) begin
            if (i < 14) begin
                s = 3'b100; e = pk(F, 1,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
            end else if (i == 14) begin
                s = 3'b110; e = pk(F, 1,0,0,1,0,0,0, 2'b00, 2'b00, 0, 0);
            end else if (i == 15) begin
                s = 3'b000; e = pk(D, 0,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
            end else if (i == 16) begin
                s = 3'b000; e = pk(E, 0,0,0,0,1,0,0, 2'b00, 2'b00, 0, 0);
            end else if (i < 31) begin
                s = 3'b000; e = pk(M, 1,1,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
            end else if (i == 31) begin
                s = 3'b010; e = pk(M, 1,1,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
            end else begin
                s = 3'b000; e = pk(W, 0,0,0,0,0,1,1, 2'b00, 2'b01, 0, 0);
            end
            {inst_valid, mem_ready, branch_taken} = s;
            #1;
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL wait_boundary cyc%0d obs=%h expected=%h", i, obs, e);
            end
            @(negedge clk);
        end
        {inst_valid, mem_ready, branch_taken} = 3'b000;
        #1;
        checks++;
        if (retired !== 32'd1 || trap !== 1'b0) begin
            failures++;
            $display("FAIL wait_boundary_retire retired=%0d trap=%b expected 1/0", retired, trap);
        end
        @(negedge clk);
    endtask

    task automatic test_store_async_reset();
        obs_t e[8];
        logic [2:0] s[8];
        obs_t x;
        do_reset();
        opcode = OPC_SW;
        s = '{3'b110, 3'b000, 3'b000, 3'b010, 3'b110, 3'b000, 3'b000, 3'b000};
        e[0] = pk(F, 1,0,0,1,0,0,0, 2'b00, 2'b00, 0, 0);
        e[1] = pk(D, 0,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
        e[2] = pk(E, 0,0,0,0,1,0,0, 2'b00, 2'b00, 0, 0);
        e[3] = pk(M, 1,1,1,0,0,0,1, 2'b00, 2'b00, 0, 0);
        e[4] = pk(F, 1,0,0,1,0,0,0, 2'b00, 2'b00, 0, 0);
        e[5] = pk(D, 0,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
        e[6] = pk(E, 0,0,0,0,1,0,0, 2'b00, 2'b00, 0, 0);
        e[7] = pk(M, 1,1,1,0,0,0,0, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 8; i++) begin
            {inst_valid, mem_ready, branch_taken} = s[i];
            #1;
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL store cyc%0d obs=%h expected=%h", i, obs, e[i]);
            end
            @(negedge clk);
        end
        {inst_valid, mem_ready, branch_taken} = 3'b000;
        #1;
        x = pk(M, 1,1,1,0,0,0,0, 2'b00, 2'b00, 0, 0);
        checks++;
        if (obs !== x || retired !== 32'd1) begin
            failures++;
            $display("FAIL store_pending obs=%h retired=%0d expected obs=%h retired=1", obs, retired, x);
        end
        #2;
        rst = 1'b1;
        #1;
        x = pk(F, 0,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
        checks++;
        if (obs !== x || retired !== 32'd0) begin
            failures++;
            $display("FAIL async_reset obs=%h retired=%0d expected obs=%h retired=0", obs, retired, x);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        x = pk(F, 1,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
        checks++;
        if (obs !== x) begin
            failures++;
            $display("FAIL refetch_after_reset obs=%h expected=%h", obs, x);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_addi();
        test_load_wait();
        test_back_to_back_branch();
        test_writeback_sel();
        test_halt_fence_ecall();
        test_illegal();
        test_mem_timeout();
        test_wait_boundary();
        test_store_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control FSM for the RV32I von Neumann core.
- Sequences one shared memory port between instruction fetch and load/store.
- Drives the instruction-register load, ALU execute, register-file write-back and PC update strobes.
- Sits between the decoder outputs and the instruction memory, register file, ALU and PC logic. Maintains a retired-instruction counter and halt/trap status.

Parameters:
- RETIRE_WIDTH, 32, width of the retired-instruction counter.
- MEM_WAIT_MAX, 15, maximum cycles a memory request may wait for mem_ready before a bus trap.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- opcode  in  7  opcode field of the instruction register.
- inst_valid  in  1  instruction memory reports the fetched address valid; sampled with mem_ready in FETCH.
- mem_ready  in  1  memory completes the current transfer this cycle.
- branch_taken  in  1  branch comparator result; valid in EXECUTE.
- mem_req  out  1  memory transfer request.
- mem_sel  out  1  address source: 0 = PC (fetch), 1 = ALU result (data).
- mem_we  out  1  memory write (store).
- ir_we  out  1  load the instruction register.
- alu_execute  out  1  ALU enable.
- rf_we  out  1  register-file write enable.
- pc_we  out  1  PC update strobe.
- pc_src  out  2  00 = PC+4, 01 = PC+imm (branch/jal), 10 = (rs1+imm)&~1 (jalr).
- wb_sel  out  2  00 = ALU, 01 = load data, 10 = PC+4, 11 = immediate/auipc sum.
- halted  out  1  sticky; set on SYSTEM instruction or trap.
- trap  out  1  sticky; illegal instruction, invalid fetch, or memory timeout.
- state  out  3  current FSM state (debug).
- retired  out  RETIRE_WIDTH  count of completed instructions.

Behaviour:
- Reset (asynchronous, any state):
  - state = FETCH.
  - halted = trap = 0, retired = 0, wait counter = 0.
  - All strobes forced 0 while rst is high.
  - mem_req rises in the first cycle after rst deasserts.
- Outputs are Moore-decoded from state and the registered opcode class, except the completion strobes. ir_we and the final pc_we/rf_we are gated with mem_ready where noted.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5. Codes 6 and 7 go to HALT with trap=1.
- FETCH:
  - Drive mem_req=1, mem_sel=0.
  - Hold until mem_ready.
  - On mem_ready with inst_valid=1: ir_we=1, go to DECODE.
  - On mem_ready with inst_valid=0: set trap, go to HALT.
- DECODE:
  - Classify opcode: alu_reg, alu_imm, load, store, branch, jal, jalr, lui, auipc, system.
  - fence or unknown opcode: set trap, go to HALT.
  - system: set halted, go to HALT.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - alu_execute=1 for alu_reg, alu_imm, load, store, jalr and auipc (address/sum generation).
  - load or store: go to MEMORY.
  - branch: pc_we=1, pc_src=01 if branch_taken else 00; retired+1; go to FETCH.
  - All others: go to WRITEBACK.
- MEMORY:
  - Drive mem_req=1, mem_sel=1, mem_we=store.
  - Hold until mem_ready.
  - store: pc_we=1, pc_src=00, retired+1, go to FETCH.
  - load: go to WRITEBACK.
- WRITEBACK:
  - rf_we=1 and pc_we=1 for one cycle; retired+1; go to FETCH.
  - wb_sel: alu = 00, load = 01, jal/jalr = 10, lui/auipc = 11.
  - pc_src: jal = 01, jalr = 10, else 00.
- HALT: absorbing; all strobes 0; exits only via reset.
- Memory handshake:
  - mem_req, mem_sel and mem_we are held stable until the cycle mem_ready is sampled high.
  - mem_ready while mem_req=0 is ignored.
  - The wait counter resets on each new request and increments per cycle without mem_ready.
  - Reaching MEM_WAIT_MAX: set trap, go to HALT.
- Latency with zero-wait memory: ALU/lui/auipc/jal/jalr 4 cycles, load 5, store 4, branch 3.
- retired wraps to 0 on overflow; no flag.
- trap implies halted; both remain set until reset.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state encoding constants.
  - opcode constants (7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111, 7'b1110011, 7'b0001111).
  - pc_src and wb_sel encodings.
- One natural sub-module: opcode_classifier. Combinational opcode to one-hot class plus illegal flag; reused by the decoder.

Test Plan:
- ADDI (0x00500093), zero-wait memory -> FETCH, DECODE, EXECUTE, WRITEBACK; rf_we=1, wb_sel=00, pc_src=00 in cycle 4; retired=1.
- LW with mem_ready delayed 3 cycles in MEMORY -> mem_req/mem_sel=1 held 4 cycles; WRITEBACK with wb_sel=01; total 8 cycles; retired=1.
- BEQ, branch_taken=1 then 0 -> pc_we=1 in EXECUTE with pc_src=01 then 00; no rf_we; 3 cycles each.
- Opcode 0x0000000F (fence), then 0x00000073 (ecall) after reset -> fence: trap=1, halted=1. Ecall: halted=1, trap=0. Both stay in HALT for 20 cycles with no strobes.
- mem_ready held low in FETCH -> trap=1 after exactly MEM_WAIT_MAX=15 wait cycles; state=5.
- rst asserted mid-MEMORY on a store -> mem_we and mem_req drop immediately (asynchronous); state=0, retired=0; first fetch issued the cycle after deassertion.
